// File: rtl/mem_master_pkg.sv
// Shared definitions for the MEM burst master and the MEM block it drives.
package mem_master_pkg;
   localparam int unsigned MEM_WORDSIZE   = 8;
   localparam int unsigned MEM_ADDR_WIDTH = 9;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR       = 2'd1,
      RD       = 2'd2,
      RD_DRAIN = 2'd3
   } state_t;
endpackage

// File: rtl/mem_beat_counter.sv
// Burst base/beat-index registers; yields the wrapping address base+k and a last-beat flag.
module mem_beat_counter
   import mem_master_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
   parameter int unsigned BURST_BITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  load_adv,
   input  logic                  advance,
   input  logic [ADDR_WIDTH-1:0] base_in,
   input  logic [BURST_BITS-1:0] len_in,
   output logic [ADDR_WIDTH-1:0] beat_addr,
   output logic                  last_beat
);
   logic [ADDR_WIDTH-1:0] base;
   logic [BURST_BITS-1:0] idx;
   logic [BURST_BITS-1:0] len;

   // load_adv starts at beat 1 when beat 0 is issued in the same cycle as the load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base <= '0;
         idx  <= '0;
         len  <= '0;
      end else if (load) begin
         base <= base_in;
         len  <= len_in;
         idx  <= load_adv ? BURST_BITS'(1) : '0;
      end else if (advance) begin
         idx  <= idx + BURST_BITS'(1);
      end
   end

   assign beat_addr = base + ADDR_WIDTH'(idx);
   assign last_beat = (idx == len);
endmodule

// File: rtl/mem_burst_master.sv
// Valid/ready command to MEM strobe converter with burst support and a 2-cycle read return path.
module mem_burst_master
   import mem_master_pkg::*;
#(
   parameter int unsigned WORDSIZE   = MEM_WORDSIZE,
   parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
   parameter int unsigned BURST_BITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [BURST_BITS-1:0] req_len,
   input  logic                  wdata_valid,
   output logic                  wdata_ready,
   input  logic [WORDSIZE-1:0]   wdata,
   output logic                  rsp_valid,
   output logic [WORDSIZE-1:0]   rsp_data,
   output logic                  rsp_last,
   output logic                  done,
   output logic                  mem_Enable,
   output logic                  mem_WE,
   output logic                  mem_RE,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [WORDSIZE-1:0]   mem_data_in,
   input  logic [WORDSIZE-1:0]   mem_data_out
);
   state_t                state;
   logic                  wr_fin;
   logic                  strobe_last;
   logic                  re_d;
   logic                  last_d;
   logic                  load;
   logic                  load_adv;
   logic                  advance;
   logic                  wr_accept;
   logic [ADDR_WIDTH-1:0] beat_addr;
   logic                  last_beat;

   assign load      = (state == IDLE) && req_valid && req_ready;
   assign load_adv  = load && !req_write;
   assign wr_accept = (state == WR) && !wr_fin && wdata_valid && wdata_ready;
   assign advance   = wr_accept || (state == RD);

   mem_beat_counter #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .BURST_BITS (BURST_BITS)
   ) u_beat_counter (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_adv  (load_adv),
      .advance   (advance),
      .base_in   (req_addr),
      .len_in    (req_len),
      .beat_addr (beat_addr),
      .last_beat (last_beat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         req_ready   <= 1'b1;
         wdata_ready <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_last    <= 1'b0;
         rsp_data    <= '0;
         done        <= 1'b0;
         mem_Enable  <= 1'b0;
         mem_WE      <= 1'b0;
         mem_RE      <= 1'b0;
         mem_address <= '0;
         mem_data_in <= '0;
         wr_fin      <= 1'b0;
         strobe_last <= 1'b0;
         re_d        <= 1'b0;
         last_d      <= 1'b0;
      end else begin
         mem_Enable  <= 1'b0;
         mem_WE      <= 1'b0;
         mem_RE      <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_last    <= 1'b0;
         done        <= 1'b0;
         strobe_last <= 1'b0;
         // read return: strobe -> MEM register -> rsp register
         re_d        <= mem_RE;
         last_d      <= mem_RE && strobe_last;
         if (re_d) begin
            rsp_valid <= 1'b1;
            rsp_data  <= mem_data_out;
            rsp_last  <= last_d;
         end

         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  if (req_write) begin
                     wdata_ready <= 1'b1;
                     state       <= WR;
                  end else begin
                     mem_Enable  <= 1'b1;
                     mem_RE      <= 1'b1;
                     mem_address <= req_addr;
                     strobe_last <= (req_len == '0);
                     state       <= (req_len == '0) ? RD_DRAIN : RD;
                  end
               end
            end
            WR: begin
               if (wr_fin) begin
                  wr_fin    <= 1'b0;
                  done      <= 1'b1;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end else if (wr_accept) begin
                  mem_Enable  <= 1'b1;
                  mem_WE      <= 1'b1;
                  mem_address <= beat_addr;
                  mem_data_in <= wdata;
                  if (last_beat) begin
                     wdata_ready <= 1'b0;
                     wr_fin      <= 1'b1;
                  end
               end
            end
            RD: begin
               mem_Enable  <= 1'b1;
               mem_RE      <= 1'b1;
               mem_address <= beat_addr;
               strobe_last <= last_beat;
               if (last_beat) state <= RD_DRAIN;
            end
            RD_DRAIN: begin
               if (re_d && last_d) begin
                  done      <= 1'b1;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a behavioural single-port RAM attached.
module tb_mem_burst_master;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid, req_ready, req_write;
   logic [8:0] req_addr;
   logic [3:0] req_len;
   logic       wdata_valid, wdata_ready;
   logic [7:0] wdata;
   logic       rsp_valid, rsp_last, done;
   logic [7:0] rsp_data;
   logic       mem_Enable, mem_WE, mem_RE;
   logic [8:0] mem_address;
   logic [7:0] mem_data_in, mem_data_out;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int rdy_cnt;

   typedef struct { int c; logic [8:0] a; logic [7:0] d; logic l; } ev_t;
   ev_t wr_q[$];
   ev_t rd_q[$];
   ev_t rsp_q[$];
   int  done_q[$];

   logic [7:0] ram [512];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_burst_master dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_len      (req_len),
      .wdata_valid  (wdata_valid),
      .wdata_ready  (wdata_ready),
      .wdata        (wdata),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .rsp_last     (rsp_last),
      .done         (done),
      .mem_Enable   (mem_Enable),
      .mem_WE       (mem_WE),
      .mem_RE       (mem_RE),
      .mem_address  (mem_address),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out)
   );

   initial begin
      for (int i = 0; i < 512; i++) ram[i] = 8'h00;
      mem_data_out = 8'h00;
   end

   always @(posedge clk) begin
      if (mem_Enable && mem_WE) ram[mem_address] <= mem_data_in;
      if (mem_Enable && mem_RE) mem_data_out <= ram[mem_address];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_Enable && mem_WE) wr_q.push_back('{cyc, mem_address, mem_data_in, 1'b0});
      if (mem_Enable && mem_RE) rd_q.push_back('{cyc, mem_address, 8'h00, 1'b0});
      if (rsp_valid) rsp_q.push_back('{cyc, 9'h000, rsp_data, rsp_last});
      if (done) done_q.push_back(cyc);
      if (req_ready) rdy_cnt++;
      if (rst_n) chk("we_re_exclusive", {31'd0, mem_WE && mem_RE}, 32'd0);
   end

   task automatic clear_logs();
      wr_q.delete(); rd_q.delete(); rsp_q.delete(); done_q.delete();
   endtask

   task automatic issue(input logic w, input logic [8:0] a, input logic [3:0] l, output int acc);
      bit ok = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = w; req_addr = a; req_len = l;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (req_ready) begin ok = 1; break; end
      end
      if (!ok) chk("req_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      acc = cyc;
      req_valid = 1'b0;
   endtask

   task automatic wr_burst(input logic [8:0] a, input logic [3:0] l, input logic [31:0] d,
                           input int stall_at, input int stall_n, output int acc);
      issue(1'b1, a, l, acc);
      for (int k = 0; k <= int'(l); k++) begin
         bit ok = 0;
         if (k == stall_at) begin
            wdata_valid = 1'b0;
            repeat (stall_n) @(posedge clk);
            #1;
         end
         wdata = d[8*k +: 8];
         wdata_valid = 1'b1;
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wdata_ready) begin ok = 1; break; end
         end
         if (!ok) chk("wdata_ready_timeout", 32'd0, 32'd1);
         @(posedge clk); #1;
      end
      wdata_valid = 1'b0;
   endtask

   task automatic wait_done(output int dc);
      bit ok = 0;
      dc = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) begin ok = 1; dc = cyc; break; end
      end
      if (!ok) chk("done_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic check_wr(input string t, input int acc, input int dc, input logic [8:0] base,
                           input int len, input logic [31:0] d, input logic [31:0] offs,
                           input int done_off);
      logic [8:0] a;
      chk({t, "_beats"}, wr_q.size(), len + 1);
      for (int k = 0; k <= len && k < wr_q.size(); k++) begin
         a = base + 9'(k);
         chk($sformatf("%s_cyc%0d", t, k), wr_q[k].c - acc, {24'd0, offs[8*k +: 8]});
         chk($sformatf("%s_addr%0d", t, k), {23'd0, wr_q[k].a}, {23'd0, a});
         chk($sformatf("%s_data%0d", t, k), {24'd0, wr_q[k].d}, {24'd0, d[8*k +: 8]});
      end
      chk({t, "_done"}, dc - acc, done_off);
   endtask

   task automatic check_rd(input string t, input int acc, input int dc, input logic [8:0] base,
                           input int len, input logic [127:0] ed);
      logic [8:0] a;
      chk({t, "_strobes"}, rd_q.size(), len + 1);
      chk({t, "_rsps"}, rsp_q.size(), len + 1);
      for (int k = 0; k <= len && k < rd_q.size(); k++) begin
         a = base + 9'(k);
         chk($sformatf("%s_rcyc%0d", t, k), rd_q[k].c - acc, k);
         chk($sformatf("%s_raddr%0d", t, k), {23'd0, rd_q[k].a}, {23'd0, a});
      end
      for (int k = 0; k <= len && k < rsp_q.size(); k++) begin
         chk($sformatf("%s_pcyc%0d", t, k), rsp_q[k].c - acc, k + 2);
         chk($sformatf("%s_pdata%0d", t, k), {24'd0, rsp_q[k].d}, {24'd0, ed[8*k +: 8]});
         chk($sformatf("%s_plast%0d", t, k), {31'd0, rsp_q[k].l}, {31'd0, k == len});
      end
      chk({t, "_done"}, dc - acc, len + 2);
   endtask

   int acc, acc2, dc;

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
      wdata_valid = 1'b0; wdata = '0;
      rdy_cnt = 0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_wdata_ready", {31'd0, wdata_ready}, 32'd0);
      chk("rst_flags", {26'd0, rsp_valid, rsp_last, done, mem_Enable, mem_WE, mem_RE}, 32'd0);
      chk("rst_buses", {7'd0, mem_address, mem_data_in, rsp_data}, 32'd0);
      rst_n = 1'b1;

      // single write then single read
      clear_logs();
      wr_burst(9'h005, 4'd0, 32'h000000A5, -1, 0, acc);
      wait_done(dc);
      check_wr("t1w", acc, dc, 9'h005, 0, 32'h000000A5, 32'h00000001, 2);
      clear_logs();
      issue(1'b0, 9'h005, 4'd0, acc);
      wait_done(dc);
      check_rd("t1r", acc, dc, 9'h005, 0, 128'hA5);

      // wrapping burst
      clear_logs();
      wr_burst(9'h1FE, 4'd3, 32'h44332211, -1, 0, acc);
      wait_done(dc);
      check_wr("t2w", acc, dc, 9'h1FE, 3, 32'h44332211, 32'h04030201, 5);
      clear_logs();
      issue(1'b0, 9'h1FE, 4'd3, acc);
      wait_done(dc);
      check_rd("t2r", acc, dc, 9'h1FE, 3, 128'h44332211);

      // write stall between beats 1 and 2
      clear_logs();
      wr_burst(9'h0A0, 4'd3, 32'hC4C3C2C1, 2, 2, acc);
      wait_done(dc);
      check_wr("t3w", acc, dc, 9'h0A0, 3, 32'hC4C3C2C1, 32'h06050201, 7);

      // max read burst; req_ready high only in the done cycle
      clear_logs();
      issue(1'b0, 9'h000, 4'd15, acc);
      rdy_cnt = 0;
      wait_done(dc);
      check_rd("t4r", acc, dc, 9'h000, 15, 128'hA500_0000_4433);
      chk("t4_ready_cycles", rdy_cnt, 1);

      // queued command held during a read burst
      clear_logs();
      issue(1'b0, 9'h1FE, 4'd3, acc);
      issue(1'b0, 9'h005, 4'd0, acc2);
      wait_done(dc);
      chk("t6_dones", done_q.size(), 2);
      chk("t6_done1", done_q[0] - acc, 5);
      chk("t6_accept2", acc2 - done_q[0], 1);
      chk("t6_rsps", rsp_q.size(), 5);
      chk("t6_rsp1_last", {24'd0, rsp_q[3].d}, 32'h44);
      chk("t6_rsp2_cyc", rsp_q[4].c - acc2, 2);
      chk("t6_rsp2_data", {24'd0, rsp_q[4].d}, 32'hA5);
      chk("t6_rsp2_last", {31'd0, rsp_q[4].l}, 32'd1);
      chk("t6_done2", dc - acc2, 2);

      // reset during beat 2 of a 4-beat write
      clear_logs();
      issue(1'b1, 9'h040, 4'd3, acc);
      for (int k = 0; k < 3; k++) begin
         wdata = 8'h91 + 8'(k);
         wdata_valid = 1'b1;
         @(posedge clk); #1;
      end
      chk("t5_strobe_live", {31'd0, mem_WE}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_strobe_killed", {30'd0, mem_Enable, mem_WE}, 32'd0);
      wdata_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("t5_rst_ready", {30'd0, req_ready, wdata_ready}, 32'd2);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("t5_wr_beats", wr_q.size(), 2);
      chk("t5_no_done", done_q.size(), 0);
      chk("t5_no_rsp", rsp_q.size(), 0);
      clear_logs();
      issue(1'b0, 9'h040, 4'd3, acc);
      wait_done(dc);
      check_rd("t5r", acc, dc, 9'h040, 3, 128'h00009291);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_burst_master.md
Name: mem_burst_master

Overview:
- Initiator side of the synchronous single-port RAM (MEM) interface; converts a valid/ready command stream into MEM control strobes (Enable, WE, RE, address, data_in) and returns read data.
- Supports single and burst transfers (up to 2^BURST_BITS beats) with address auto-increment.
- Sits between the ALU datapath/test sequencer and the MEM block. It owns all MEM timing, so upstream logic never toggles WE/RE directly.

Parameters:
- WORDSIZE, 8, data word width; matches MEM WORDSIZE.
- ADDR_WIDTH, 9, word-address width; 2^ADDR_WIDTH words (512 default).
- BURST_BITS, 4, burst length field width; max burst is 2^BURST_BITS beats.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when req_valid and req_ready are both high at a rising edge.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_WIDTH  burst base address.
- req_len  in  BURST_BITS  beats minus 1.
- wdata_valid  in  1  write beat valid.
- wdata_ready  out  1  write beat accepted on (wdata_valid & wdata_ready) at the edge.
- wdata  in  WORDSIZE  write beat data.
- rsp_valid  out  1  one-cycle read data pulse; no backpressure.
- rsp_data  out  WORDSIZE  read beat data.
- rsp_last  out  1  high with the final rsp_valid of a burst.
- done  out  1  one-cycle pulse when a burst completes (write or read).
- mem_Enable  out  1  MEM enable; high = enabled.
- mem_WE  out  1  MEM write enable.
- mem_RE  out  1  MEM read enable.
- mem_address  out  ADDR_WIDTH  MEM word address.
- mem_data_in  out  WORDSIZE  MEM write data.
- mem_data_out  in  WORDSIZE  MEM read data; registered in MEM, valid the cycle after an RE strobe.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - req_ready=1; wdata_ready=0.
  - rsp_valid, rsp_last, done, mem_Enable, mem_WE, mem_RE all 0.
  - mem_address=0, mem_data_in=0, rsp_data=0.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states: IDLE, WR, RD, RD_DRAIN.
- IDLE:
  - req_ready=1.
  - On accept, latch req_write, req_addr, and beat counter = req_len.
  - req_ready drops in the next cycle.
  - Next state is WR if req_write=1, else RD.
  - wdata_valid is ignored in IDLE.
- WR:
  - wdata_ready=1.
  - Each accepted beat k drives mem_Enable=1, mem_WE=1, mem_RE=0, mem_address=base+k, mem_data_in=wdata for exactly the one cycle after acceptance.
  - Strobes drop to 0 in any cycle with no accepted beat, so stalls insert idle cycles.
  - After the strobe of the last beat, done=1 for one cycle, req_ready=1 in that same cycle, and the FSM returns to IDLE.
- RD:
  - One strobe per cycle, back-to-back, no stalls: mem_Enable=1, mem_RE=1, mem_WE=0, mem_address=base+k.
  - Beat 0 strobe is in the first cycle after acceptance.
  - After the last strobe, go to RD_DRAIN.
- Read timing:
  - Beat k strobe is in cycle C.
  - MEM updates mem_data_out at the end of C.
  - The master registers it at the end of C+1.
  - rsp_valid=1 and rsp_data are presented in cycle C+2.
  - Read latency: 2 cycles from strobe to rsp_valid, 3 cycles from command acceptance to the first rsp.
- RD_DRAIN:
  - Waits for the final rsp.
  - rsp_last and done are asserted with the final rsp_valid, and req_ready=1 in that same cycle.
- Address arithmetic:
  - base+k is computed modulo 2^ADDR_WIDTH; bursts wrap from the top address to 0.
  - The carry is discarded and not flagged.
- mem_WE and mem_RE are never high together; the bench asserts this every cycle.
- req_valid while busy: held off by req_ready=0, never dropped. The command stays pending until IDLE.
- Reset mid-burst:
  - Strobes deassert immediately, so MEM sees no write at the next edge.
  - Remaining beats and pending responses are discarded; no rsp_valid and no done.

Decomposition:
- Shared package mem_master_pkg holds:
  - FSM state localparams (IDLE=2'd0, WR=2'd1, RD=2'd2, RD_DRAIN=2'd3).
  - Defaults for WORDSIZE and ADDR_WIDTH, shared with MEM.
- One sub-module: mem_beat_counter. It holds the base address and beat index registers, produces the wrapping base+k address, and outputs a last_beat flag.
- The FSM and read pipeline stay in the top module.

Test Plan:
1. Single write: addr 0x005, data 0xA5, len 0 → one cycle of Enable=1, WE=1, address 0x005; done pulse. Then a single read of 0x005 → rsp_valid 3 cycles after acceptance with rsp_data=0xA5 and rsp_last=1.
2. Wrapping burst: write len 3 at 0x1FE with data 0x11, 0x22, 0x33, 0x44 → addresses 0x1FE, 0x1FF, 0x000, 0x001. Read-back burst returns the same four words in order on consecutive cycles, with rsp_last on 0x44.
3. Write stall: drop wdata_valid for 2 cycles between beats 1 and 2 → WE low for exactly those 2 cycles; address sequence unbroken; done only after beat 3.
4. Max read burst: len 15 from 0x000 → 16 consecutive RE strobes and 16 consecutive rsp_valid cycles. WE and RE are never high together. req_ready stays low until the final rsp.
5. Reset mid-burst: assert rst_n low during beat 2 of a 4-beat write → strobes go to 0 asynchronously. A later read shows beats 0–1 written and beats 2–3 unchanged (still 0x00). No done pulse.
6. Queued command: hold req_valid with a second command during a read burst → it is accepted in the first cycle req_ready=1 after the first burst's done, and nothing is lost.
